// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
package mult_share_pkg;

    localparam int unsigned ArgW = 16;
    localparam int unsigned ResW = 32;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitRes,
        StResp,
        StGap
    } state_e;

    function automatic logic even_parity(input logic [ResW-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    input  logic            en_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    always_comb begin
        int unsigned j;
        j       = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (en_i && !valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one parity-protected 16x16 multiplier between NumReq requesters,
// round-robin, with per-operation timeout and a forced m_req low gap.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int unsigned NumReq        = 4,
    parameter int unsigned TimeoutCycles = 64,
    parameter int unsigned GapCycles     = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumReq-1:0]        s_valid_i,
    output logic [NumReq-1:0]        s_ready_o,
    input  logic [NumReq*ArgW-1:0]   s_arg_a_i,
    input  logic [NumReq-1:0]        s_arg_a_parity_i,
    input  logic [NumReq*ArgW-1:0]   s_arg_b_i,
    input  logic [NumReq-1:0]        s_arg_b_parity_i,
    output logic [NumReq-1:0]        r_valid_o,
    input  logic [NumReq-1:0]        r_ready_i,
    output logic [ResW-1:0]          r_result_o,
    output logic                     r_result_parity_o,
    output logic                     r_arg_parity_error_o,
    output logic                     r_result_parity_error_o,
    output logic                     r_timeout_o,
    output logic                     m_req_o,
    output logic [ArgW-1:0]          m_arg_a_o,
    output logic                     m_arg_a_parity_o,
    output logic [ArgW-1:0]          m_arg_b_o,
    output logic                     m_arg_b_parity_o,
    input  logic                     m_ack_i,
    input  logic [ResW-1:0]          m_result_i,
    input  logic                     m_result_parity_i,
    input  logic                     m_result_rdy_i,
    input  logic                     m_arg_parity_error_i,
    output logic                     busy_o
);

    localparam int unsigned IdxW   = $clog2(NumReq);
    localparam int unsigned CntMax = (TimeoutCycles > GapCycles) ? TimeoutCycles : GapCycles;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     ptr_q, grant_id_q;
    logic [NumReq-1:0]   s_ready_q;
    logic [ArgW-1:0]     m_arg_a_q, m_arg_b_q;
    logic                m_arg_a_par_q, m_arg_b_par_q;
    logic [ResW-1:0]     r_result_q;
    logic                r_result_par_q, r_arg_perr_q, r_res_perr_q, r_timeout_q;

    logic [NumReq-1:0]   arb_gnt;
    logic [IdxW-1:0]     arb_idx;
    logic                arb_valid;
    logic                in_op, res_fire, to_fire;

    rr_arbiter #(
        .N    (NumReq),
        .IdxW (IdxW)
    ) u_rr_arbiter (
        .req_i   (s_valid_i),
        .ptr_i   (ptr_q),
        .en_i    (state_q == StIdle),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign in_op    = (state_q == StIssue) || (state_q == StWaitRes);
    assign res_fire = in_op && m_result_rdy_i;
    // A result arriving on the timeout cycle takes precedence over the abort.
    assign to_fire  = in_op && !m_result_rdy_i && (cnt_q == CntW'(TimeoutCycles - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d = StIssue;
                    cnt_d   = '0;
                end
            end
            StIssue, StWaitRes: begin
                cnt_d = cnt_q + 1'b1;
                if (res_fire || to_fire) begin
                    state_d = StResp;
                end else if (state_q == StIssue && m_ack_i) begin
                    state_d = StWaitRes;
                end
            end
            StResp: begin
                if (r_ready_i[grant_id_q]) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
            StGap: begin
                if (cnt_q == CntW'(GapCycles - 1)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            ptr_q          <= '0;
            grant_id_q     <= '0;
            s_ready_q      <= '0;
            m_arg_a_q      <= '0;
            m_arg_b_q      <= '0;
            m_arg_a_par_q  <= 1'b0;
            m_arg_b_par_q  <= 1'b0;
            r_result_q     <= '0;
            r_result_par_q <= 1'b0;
            r_arg_perr_q   <= 1'b0;
            r_res_perr_q   <= 1'b0;
            r_timeout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_ready_q <= arb_gnt;
            if (arb_valid) begin
                grant_id_q    <= arb_idx;
                ptr_q         <= (arb_idx == IdxW'(NumReq - 1)) ? '0 : arb_idx + 1'b1;
                m_arg_a_q     <= s_arg_a_i[arb_idx*ArgW +: ArgW];
                m_arg_b_q     <= s_arg_b_i[arb_idx*ArgW +: ArgW];
                m_arg_a_par_q <= s_arg_a_parity_i[arb_idx];
                m_arg_b_par_q <= s_arg_b_parity_i[arb_idx];
            end
            if (res_fire) begin
                r_result_q     <= m_result_i;
                r_result_par_q <= m_result_parity_i;
                r_arg_perr_q   <= m_arg_parity_error_i;
                r_res_perr_q   <= even_parity(m_result_i) != m_result_parity_i;
                r_timeout_q    <= 1'b0;
            end else if (to_fire) begin
                r_result_q     <= '0;
                r_result_par_q <= 1'b0;
                r_arg_perr_q   <= 1'b0;
                r_res_perr_q   <= 1'b0;
                r_timeout_q    <= 1'b1;
            end
        end
    end

    always_comb begin
        r_valid_o = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            r_valid_o[i] = (state_q == StResp) && (grant_id_q == IdxW'(i));
        end
    end

    assign s_ready_o               = s_ready_q;
    assign m_req_o                 = in_op;
    assign m_arg_a_o               = m_arg_a_q;
    assign m_arg_b_o               = m_arg_b_q;
    assign m_arg_a_parity_o        = m_arg_a_par_q;
    assign m_arg_b_parity_o        = m_arg_b_par_q;
    assign r_result_o              = r_result_q;
    assign r_result_parity_o       = r_result_par_q;
    assign r_arg_parity_error_o    = r_arg_perr_q;
    assign r_result_parity_error_o = r_res_perr_q;
    assign r_timeout_o             = r_timeout_q;
    assign busy_o                  = (state_q != StIdle);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: vector table with a scoreboard queue, plus
// round-robin, ignore-outside-op and mid-operation reset sequences.
module tb_mult_share_arbiter;

    localparam int NR    = 4;
    localparam int NEVER = 255;

    typedef struct {
        int          req;
        logic [15:0] a;
        logic        pa;
        logic [15:0] b;
        logic        pb;
        int          ack;
        int          rdy;
        logic [31:0] mres;
        logic        mpar;
        logic        maerr;
        logic [31:0] eres;
        logic        epar;
        logic        eaerr;
        logic        eperr;
        logic        eto;
        int          elat;
    } vec_t;

    logic           clk, rst_n;
    logic [NR-1:0]  s_valid, s_ready, s_a_par, s_b_par, r_valid, r_ready;
    logic [NR*16-1:0] s_arg_a, s_arg_b;
    logic [31:0]    r_result, m_result;
    logic           r_result_parity, r_arg_perr, r_res_perr, r_timeout;
    logic           m_req, m_a_par, m_b_par, m_ack, m_result_parity, m_result_rdy, m_arg_perr;
    logic [15:0]    m_arg_a, m_arg_b;
    logic           busy;

    int   n_pass = 0;
    int   n_total = 0;
    vec_t sb[$];
    vec_t vecs[6];

    mult_share_arbiter #(
        .NumReq        (NR),
        .TimeoutCycles (64),
        .GapCycles     (1)
    ) dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .s_valid_i               (s_valid),
        .s_ready_o               (s_ready),
        .s_arg_a_i               (s_arg_a),
        .s_arg_a_parity_i        (s_a_par),
        .s_arg_b_i               (s_arg_b),
        .s_arg_b_parity_i        (s_b_par),
        .r_valid_o               (r_valid),
        .r_ready_i               (r_ready),
        .r_result_o              (r_result),
        .r_result_parity_o       (r_result_parity),
        .r_arg_parity_error_o    (r_arg_perr),
        .r_result_parity_error_o (r_res_perr),
        .r_timeout_o             (r_timeout),
        .m_req_o                 (m_req),
        .m_arg_a_o               (m_arg_a),
        .m_arg_a_parity_o        (m_a_par),
        .m_arg_b_o               (m_arg_b),
        .m_arg_b_parity_o        (m_b_par),
        .m_ack_i                 (m_ack),
        .m_result_i              (m_result),
        .m_result_parity_i       (m_result_parity),
        .m_result_rdy_i          (m_result_rdy),
        .m_arg_parity_error_i    (m_arg_perr),
        .busy_o                  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, exp);
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int   c;
        int   gi;
        logic [NR-1:0] oh;
        @(negedge clk);
        s_arg_a[v.req*16 +: 16] = v.a;
        s_arg_b[v.req*16 +: 16] = v.b;
        s_a_par[v.req] = v.pa;
        s_b_par[v.req] = v.pb;
        s_valid[v.req] = 1'b1;
        sb.push_back(v);
        for (gi = 0; gi < 10; gi++) begin
            @(negedge clk);
            if (s_ready != 0) break;
        end
        s_valid[v.req] = 1'b0;
        e  = sb.pop_front();
        oh = 4'b0001 << e.req;
        if (gi == 10) begin
            check("grant_seen", 0, 1);
            return;
        end
        check("grant_latency", gi, 0);
        check("s_ready_onehot", s_ready, oh);
        check("m_req_issue", m_req, 1);
        check("m_arg_a", {m_arg_a, m_a_par}, {e.a, e.pa});
        check("m_arg_b", {m_arg_b, m_b_par}, {e.b, e.pb});
        m_result = e.mres;
        m_result_parity = e.mpar;
        m_arg_perr = e.maerr;
        for (c = 0; c < 100; c++) begin
            m_ack = (c == e.ack);
            m_result_rdy = (c == e.rdy);
            @(negedge clk);
            if (r_valid != 0) break;
        end
        m_ack = 1'b0;
        m_result_rdy = 1'b0;
        m_result = ~e.mres;
        m_result_parity = ~e.mpar;
        m_arg_perr = ~e.maerr;
        check("resp_latency", c + 1, e.elat);
        check("r_valid", r_valid, oh);
        check("m_req_resp", m_req, 0);
        check("r_result", r_result, e.eres);
        check("r_flags", {r_result_parity, r_arg_perr, r_res_perr, r_timeout},
              {e.epar, e.eaerr, e.eperr, e.eto});
        r_ready = ~oh;
        @(negedge clk);
        check("r_valid_hold", r_valid, oh);
        check("r_result_hold", r_result, e.eres);
        r_ready = oh;
        @(negedge clk);
        r_ready = '0;
        check("gap_state", {busy, m_req, r_valid}, {1'b1, 1'b0, 4'b0000});
        @(negedge clk);
        check("idle_after_gap", busy, 0);
    endtask

    initial begin
        int   gi;
        int   c;
        int   order[$];
        logic [NR-1:0] gnt;

        rst_n = 1'b0;
        s_valid = '0; r_ready = '0;
        s_arg_a = {$urandom, $urandom};
        s_arg_b = {$urandom, $urandom};
        s_a_par = 4'($urandom);
        s_b_par = 4'($urandom);
        m_ack = 1'b0; m_result_rdy = 1'b0; m_result = '0;
        m_result_parity = 1'b0; m_arg_perr = 1'b0;

        // req, a, pa, b, pb, ack, rdy, mres, mpar, maerr, eres, epar, eaerr, eperr, eto, elat
        vecs[0] = '{1, 16'h0003, 0, 16'hFFFE, 1, 2, 4, 32'hFFFFFFFA, 0, 0,
                    32'hFFFFFFFA, 0, 0, 0, 0, 5};
        vecs[1] = '{2, 16'h8000, 0, 16'h0002, 1, 1, 3, 32'h00000000, 0, 1,
                    32'h00000000, 0, 1, 0, 0, 4};
        vecs[2] = '{0, 16'h7FFF, 1, 16'h7FFF, 1, 0, 2, 32'h3FFF0001, 0, 0,
                    32'h3FFF0001, 0, 0, 1, 0, 3};
        vecs[3] = '{3, 16'h0005, 0, 16'h0007, 1, NEVER, 0, 32'h00000023, 1, 0,
                    32'h00000023, 1, 0, 0, 0, 1};
        vecs[4] = '{1, 16'h1234, 1, 16'h0001, 1, 0, NEVER, 32'hDEADBEEF, 1, 1,
                    32'h00000000, 0, 0, 0, 1, 64};
        vecs[5] = '{2, 16'hFFFF, 0, 16'hFFFF, 0, 0, 63, 32'h00000001, 1, 0,
                    32'h00000001, 1, 0, 0, 0, 64};

        repeat (2) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_m_req", m_req, 0);
        check("rst_m_args", {m_arg_a, m_a_par, m_arg_b, m_b_par}, 0);
        check("rst_r_result", r_result, 0);
        check("rst_r_flags", {r_result_parity, r_arg_perr, r_res_perr, r_timeout}, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Multiplier handshakes while idle must not start anything.
        m_ack = 1'b1; m_result_rdy = 1'b1;
        repeat (2) @(negedge clk);
        m_ack = 1'b0; m_result_rdy = 1'b0;
        check("idle_ignore", {busy, m_req, r_valid, s_ready}, 0);

        // All requesters hold valid: expect strict rotation starting after the last winner (2).
        order = '{3, 0, 1, 2, 3};
        s_valid = 4'b1111;
        m_result = 32'h0000_1234;
        m_result_parity = 1'b1;
        for (int n = 0; n < 5; n++) begin
            for (gi = 0; gi < 10; gi++) begin
                @(negedge clk);
                if (s_ready != 0) break;
            end
            if (gi == 10) begin
                check("rr_grant_seen", 0, 1);
                break;
            end
            gnt = s_ready;
            check("rr_grant", gnt, 4'b0001 << order.pop_front());
            for (c = 0; c < 20; c++) begin
                m_result_rdy = (c == 1);
                @(negedge clk);
                if (c == 0) check("rr_s_ready_pulse", s_ready, 0);
                if (r_valid != 0) break;
            end
            m_result_rdy = 1'b0;
            check("rr_r_valid", r_valid, gnt);
            r_ready = r_valid;
            @(negedge clk);
            r_ready = '0;
            if (n == 4) s_valid = '0;
            check("rr_gap_m_req", m_req, 0);
        end
        repeat (2) @(negedge clk);

        // Reset while waiting for the result; pointer must return to requester 0.
        s_arg_a[2*16 +: 16] = 16'hA5A5;
        s_valid[2] = 1'b1;
        for (gi = 0; gi < 10; gi++) begin
            @(negedge clk);
            if (s_ready != 0) break;
        end
        s_valid = '0;
        check("mid_grant", s_ready, 4'b0100);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        @(negedge clk);
        check("mid_waitres", {busy, m_req, m_arg_a}, {1'b1, 1'b1, 16'hA5A5});
        rst_n = 1'b0;
        #1;
        check("async_rst_busy_req", {busy, m_req}, 0);
        check("async_rst_valid_ready", {r_valid, s_ready}, 0);
        check("async_rst_args", {m_arg_a, r_result, r_timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        s_valid = 4'b1111;
        for (gi = 0; gi < 10; gi++) begin
            @(negedge clk);
            if (s_ready != 0 || r_valid != 0) break;
        end
        check("post_rst_no_resp", r_valid, 0);
        check("post_rst_grant", s_ready, 4'b0001);
        s_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one 16x16 signed parity-protected multiplier between NUM_REQ independent requesters.
- Arbitrates round-robin and latches the winner's operands.
- Drives the multiplier req/ack/result_rdy handshake, captures the result, and returns it to the winning requester with parity and timeout status.
- Sits between client blocks and the single multiplier instance.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- TIMEOUT_CYCLES, 64: maximum cycles from req assertion to result_rdy before abort.
- GAP_CYCLES, 1: idle cycles with m_req low between consecutive operations (>=1).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  NUM_REQ  per-requester operand valid.
- s_ready  out  NUM_REQ  one-hot acceptance pulse.
- s_arg_a  in  NUM_REQ*16  packed signed operand A, slice i = requester i.
- s_arg_a_parity  in  NUM_REQ  even-parity bit of A.
- s_arg_b  in  NUM_REQ*16  packed signed operand B.
- s_arg_b_parity  in  NUM_REQ  even-parity bit of B.
- r_valid  out  NUM_REQ  one-hot response valid.
- r_ready  in  NUM_REQ  response accept.
- r_result  out  32  signed product (shared bus).
- r_result_parity  out  1  parity bit returned by the multiplier.
- r_arg_parity_error  out  1  multiplier flagged an operand parity error.
- r_result_parity_error  out  1  ^r_result != r_result_parity.
- r_timeout  out  1  operation aborted by timeout.
- m_req  out  1  to multiplier: operands valid.
- m_arg_a  out  16  to multiplier.
- m_arg_a_parity  out  1  to multiplier.
- m_arg_b  out  16  to multiplier.
- m_arg_b_parity  out  1  to multiplier.
- m_ack  in  1  multiplier operand acknowledge.
- m_result  in  32  multiplier product.
- m_result_parity  in  1  multiplier result parity.
- m_result_rdy  in  1  multiplier result ready.
- m_arg_parity_error  in  1  multiplier operand-parity error.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; the following are all 0: s_ready, r_valid, m_req, m_arg_*, r_result, all r_* flags, busy, timeout counter. RR pointer = 0, so requester 0 has highest priority.
- FSM states: IDLE, ISSUE, WAIT_RES, RESP, GAP.
- IDLE:
  - If any s_valid, the rr_arbiter picks the first set bit at or after the pointer, wrapping.
  - Same edge: pulse s_ready[winner] for exactly one cycle and latch the winner's operands, parities and index into m_arg_* and grant_id.
  - Pointer := winner+1 mod NUM_REQ. Next state ISSUE.
  - Latency from s_valid to m_req is 1 cycle.
- ISSUE: m_req=1, operands stable.
  - m_ack seen -> WAIT_RES.
  - m_result_rdy seen (with or without ack) -> capture result, go to RESP.
- WAIT_RES: m_req stays 1. On m_result_rdy, capture m_result, m_result_parity and m_arg_parity_error; compute r_result_parity_error; go to RESP.
- Timeout counter:
  - Clears on entering ISSUE and increments each cycle in ISSUE/WAIT_RES.
  - On reaching TIMEOUT_CYCLES without result_rdy: r_timeout=1, r_result=0, other flags 0, go to RESP.
- RESP:
  - m_req=0; r_valid[grant_id]=1.
  - r_result and flags are held stable until r_ready[grant_id]=1, then go to GAP.
  - r_ready of non-granted requesters is ignored.
- GAP:
  - m_req=0 for GAP_CYCLES, then IDLE.
  - Guarantees a req low phase so the multiplier sees a fresh req rising edge.
- Arithmetic: the block only registers and forwards values; it does not compute the product.
- Boundaries:
  - A requester may hold s_valid through its own response; the RR pointer ensures other pending requesters are served before it repeats.
  - Single requester continuously valid: served back-to-back, every operation separated by GAP.
  - s_valid deasserted before grant: no grant, no side effects.
  - m_ack or m_result_rdy outside ISSUE/WAIT_RES: ignored.
  - Timeout and result_rdy in the same cycle: the result wins and r_timeout=0.
  - Reset mid-operation: immediate return to the reset values; no response is issued for the in-flight request.

Decomposition:
- Package mult_share_pkg: state enum (IDLE, ISSUE, WAIT_RES, RESP, GAP), ARG_W=16, RES_W=32, and an even-parity function.
- Sub-module rr_arbiter: parameter N; inputs req vector, pointer and enable; outputs one-hot grant and index. It is purely combinational; the pointer register lives in the top.

Test Plan:
- Requester 1 only: A=0x0003 (parity 0), B=0xFFFE (parity 1); multiplier acks after 2 cycles, result_rdy after 4 with 0xFFFFFFFA and parity 0 -> r_valid=0b0010, r_result=0xFFFFFFFA, all flags 0, m_req low after result_rdy.
- All 4 requesters valid after reset -> grant order 0,1,2,3,0. s_ready is a one-hot single-cycle pulse each time, and m_req is low for at least 1 cycle between operations.
- Bad A parity: 0x8000 with parity 0; multiplier returns arg_parity_error=1 -> r_arg_parity_error=1 to the requester, FSM returns to IDLE.
- Multiplier returns 0x3FFF0001 with parity 0 (actual ^=1) -> r_result_parity_error=1.
- Multiplier never raises result_rdy, TIMEOUT_CYCLES=64 -> r_timeout=1 and r_result=0 exactly 64 cycles after m_req rose; the next requester is served normally.
- rst_n pulsed low during WAIT_RES -> all outputs 0 asynchronously, no r_valid; after release, requester 0 is granted first.
